// File: rtl/pulse_train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared types and default timing for the pulse train generator.
//               STATES enumerates the controller states; the ON/OFF defaults
//               give 0.5 s periods on the 50 MHz OTTER clock.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_train_pkg;

  // STATES: controller state encoding
  typedef enum logic [1:0] {
    ST_idle = 2'd0,
    ST_on   = 2'd1,
    ST_off  = 2'd2,
    ST_done = 2'd3
  } states_t;

  localparam int DEFAULT_ON_CLKS  = 25_000_000;
  localparam int DEFAULT_OFF_CLKS = 25_000_000;

endpackage
`default_nettype wire

// File: rtl/pulse_train_gen_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : COUNT_W-bit up counter with synchronous clear and increment,
//               and a terminal-count flag comparing against a runtime limit.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset
//               clr_i    - clear to zero (wins over increment)
//               inc_i    - increment by one
//               limit_i  - terminal count value
//               tc_o     - high while count equals limit_i
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter #(
  parameter int COUNT_W = 26
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [COUNT_W-1:0] limit_i,
  output logic               tc_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : On a single-cycle TRIG, drives PULSE_OUT with NUM_PULSES
//               pulses of ON_CLKS high / OFF_CLKS low, then strobes DONE for
//               one cycle. BUSY covers the whole train plus the DONE cycle.
//               All outputs are Moore, decoded from the present state.
// Ports       : CLK        - 50 MHz OTTER clock
//               RST        - synchronous active-high reset (aborts a train)
//               TRIG       - single-cycle start request
//               NUM_PULSES - pulse count, sampled when a trigger is accepted
//               PULSE_OUT  - timed output waveform
//               BUSY       - train in progress
//               DONE       - single-cycle completion strobe
// Options     : PULSE_TRAIN_RETRIGGER_EN - when defined, a non-zero trigger
//               during ST_on/ST_off restarts the train without a DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int ON_CLKS  = DEFAULT_ON_CLKS,
  parameter int OFF_CLKS = DEFAULT_OFF_CLKS,
  parameter int COUNT_W  = 26,
  parameter int NUM_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TRIG,
  input  logic [NUM_W-1:0] NUM_PULSES,
  output logic             PULSE_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [COUNT_W-1:0] ON_LIMIT  = COUNT_W'(ON_CLKS - 1);
  localparam logic [COUNT_W-1:0] OFF_LIMIT = COUNT_W'(OFF_CLKS - 1);

  states_t            state_q;
  states_t            state_d;
  logic [NUM_W-1:0]   remain_q;
  logic [NUM_W-1:0]   remain_d;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               cnt_tc;
  logic [COUNT_W-1:0] cnt_limit;
  logic               start_ok;

  assign start_ok  = TRIG && (NUM_PULSES != '0);
  // One shared counter; the terminal value depends on which half-period we are in.
  assign cnt_limit = (state_q == ST_on) ? ON_LIMIT : OFF_LIMIT;

  period_counter #(
    .COUNT_W (COUNT_W)
  ) u_period_counter (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i (cnt_limit),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_idle;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    PULSE_OUT = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;

    case (state_q)
      ST_idle: begin
        cnt_clr = 1'b1;
        if (start_ok) begin
          remain_d = NUM_PULSES;
          state_d  = ST_on;
        end
      end
      ST_on: begin
        PULSE_OUT = 1'b1;
        BUSY      = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = ST_off;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_off: begin
        BUSY = 1'b1;
        if (cnt_tc) begin
          cnt_clr  = 1'b1;
          remain_d = remain_q - NUM_W'(1);
          // Every pulse, including the last, gets a full OFF period.
          state_d  = (remain_q == NUM_W'(1)) ? ST_done : ST_on;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_done: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_idle;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_idle;
      end
    endcase

`ifdef PULSE_TRAIN_RETRIGGER_EN
    // Restart overrides the normal progression; the aborted train gets no DONE.
    if (((state_q == ST_on) || (state_q == ST_off)) && start_ok) begin
      remain_d = NUM_PULSES;
      cnt_clr  = 1'b1;
      cnt_inc  = 1'b0;
      state_d  = ST_on;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Self-checking bench for pulse_train_gen with ON_CLKS=3,
//               OFF_CLKS=2. A timeline model (cycles elapsed since the
//               accepted trigger) predicts PULSE_OUT/BUSY/DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

  localparam int ON      = 3;
  localparam int OFF     = 2;
  localparam int P       = ON + OFF;
  localparam int COUNT_W = 4;
  localparam int NUM_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig;
  logic [NUM_W-1:0] num;
  logic             pulse_out;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  // Timeline model: a train is "active" for n*P+1 cycles after its trigger.
  bit m_active = 1'b0;
  int m_el     = 0;
  int m_n      = 0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .ON_CLKS  (ON),
    .OFF_CLKS (OFF),
    .COUNT_W  (COUNT_W),
    .NUM_W    (NUM_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .TRIG       (trig),
    .NUM_PULSES (num),
    .PULSE_OUT  (pulse_out),
    .BUSY       (busy),
    .DONE       (done)
  );

  function automatic logic [2:0] m_exp();
    logic p, b, d;
    b = m_active;
    p = m_active && (m_el <= m_n * P) && (((m_el - 1) % P) < ON);
    d = m_active && (m_el == m_n * P + 1);
    return {p, b, d};
  endfunction

  task automatic m_update(input logic t, input logic [NUM_W-1:0] n, input logic r);
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
`ifdef PULSE_TRAIN_RETRIGGER_EN
      if (t && (n != 0) && (m_el <= m_n * P)) begin
        m_el = 1;
        m_n  = int'(n);
      end else begin
        m_el++;
        if (m_el > m_n * P + 1) m_active = 1'b0;
      end
`else
      m_el++;
      if (m_el > m_n * P + 1) m_active = 1'b0;
`endif
    end else if (t && (n != 0)) begin
      m_active = 1'b1;
      m_el     = 1;
      m_n      = int'(n);
    end
  endtask

  // Apply inputs for one cycle, advance through the edge, sample 1 time unit later.
  task automatic step(input logic t, input logic [NUM_W-1:0] n, input logic r);
    trig = t;
    num  = n;
    rst  = r;
    @(posedge clk);
    m_update(t, n, r);
    #1;
    trig = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b1);
    step(1'b1, 4'd5, 1'b1);
    tests++;
    if ({pulse_out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=000", {pulse_out, busy, done});
    end
    step(1'b0, '0, 1'b0);
    tests++;
    if ({pulse_out, busy, done} !== m_exp()) begin
      fails++;
      $display("FAIL reset_idle got=%b exp=%b", {pulse_out, busy, done}, m_exp());
    end
  endtask

  task automatic test_basic();
    logic [2:0] spec;
    step(1'b1, 4'd2, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      spec = {((c >= 1 && c <= 3) || (c >= 6 && c <= 8)), (c >= 1 && c <= 11), (c == 11)};
      tests++;
      if ({pulse_out, busy, done} !== spec) begin
        fails++;
        $display("FAIL basic_timeline cyc=%0d got=%b exp=%b", c, {pulse_out, busy, done}, spec);
      end
      tests++;
      if ({pulse_out, busy, done} !== m_exp()) begin
        fails++;
        $display("FAIL basic_model cyc=%0d got=%b exp=%b", c, {pulse_out, busy, done}, m_exp());
      end
      if (c < 12) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  // Called right after test_basic: cycle 12 is the first idle cycle.
  task automatic test_back_to_back();
    step(1'b1, 4'($urandom_range(1, 15)), 1'b0);
    tests++;
    if ({pulse_out, busy, done} !== 3'b110) begin
      fails++;
      $display("FAIL back_to_back cyc=13 got=%b exp=110", {pulse_out, busy, done});
    end
    for (int c = 0; c < 80; c++) step(1'b0, '0, 1'b0);
    tests++;
    if ({pulse_out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL back_to_back_drain got=%b exp=000", {pulse_out, busy, done});
    end
  endtask

  task automatic test_zero_count();
    int bad = 0;
    step(1'b1, 4'd0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if ({pulse_out, busy, done} !== 3'b000) bad++;
      step(1'b0, '0, 1'b0);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL zero_count active_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_busy_trigger();
    int done_cyc = -1;
`ifdef PULSE_TRAIN_RETRIGGER_EN
    int exp_done = 18;
`else
    int exp_done = 6;
`endif
    step(1'b1, 4'd1, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      tests++;
      if ({pulse_out, busy, done} !== m_exp()) begin
        fails++;
        $display("FAIL busy_trig_model cyc=%0d got=%b exp=%b", c, {pulse_out, busy, done}, m_exp());
      end
      if (done && done_cyc < 0) done_cyc = c;
      step(c == 2, 4'd3, 1'b0);
    end
    tests++;
    if (done_cyc != exp_done) begin
      fails++;
      $display("FAIL busy_trig_done_cycle got=%0d exp=%0d", done_cyc, exp_done);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] spec;
    int         e;
    step(1'b1, 4'd3, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      e = c - 7;
      if (c <= 4)      spec = {(c <= 3), 1'b1, 1'b0};
      else if (c <= 7) spec = 3'b000;
      else             spec = {(((e - 1) % P) < ON), 1'b1, 1'b0};
      tests++;
      if ({pulse_out, busy, done} !== spec) begin
        fails++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, {pulse_out, busy, done}, spec);
      end
      step(c == 7, 4'd3, c == 4);
    end
    for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b0);
  endtask

  task automatic test_max_count();
    int  done_cyc = -1;
    int  highs    = 0;
    logic prev    = 1'b0;
    step(1'b1, 4'hF, 1'b0);
    for (int c = 1; c <= 80; c++) begin
      if (pulse_out && !prev) highs++;
      prev = pulse_out;
      if (done && done_cyc < 0) done_cyc = c;
      step(1'b0, '0, 1'b0);
    end
    tests++;
    if (highs != 15) begin
      fails++;
      $display("FAIL max_count high_periods got=%0d exp=15", highs);
    end
    tests++;
    if (done_cyc != 76) begin
      fails++;
      $display("FAIL max_count done_cycle got=%0d exp=76", done_cyc);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 149) == 0);
      tests++;
      if ({pulse_out, busy, done} !== m_exp()) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_model step=%0d got=%b exp=%b", c, {pulse_out, busy, done}, m_exp());
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    trig = 1'b0;
    num  = '0;
    #2;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_count();
    test_busy_trigger();
    test_reset_mid();
    test_max_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
